// File: rtl/cmd_bus_checker_if.sv
// Driver -> DDR2 controller command bus.
//   cmd      : 0/7 NOP, 1 SCR, 2 SCW, 3 BLKR, 4 BLKW, 5 ATR, 6 ATW
//   sz       : block/atomic size code
//   op       : atomic op code
//   fetching : controller takes the command / block-write beat this cycle
//   din      : write data
//   addr     : {row, ..., bank, col}
// master: the driving side. slave: a passive observer (all inputs).
interface cmd_bus_checker_if #(
  parameter int ADDR_W = 25,
  parameter int DATA_W = 16
);
  logic [2:0]        cmd;
  logic [1:0]        sz;
  logic [2:0]        op;
  logic              fetching;
  logic [DATA_W-1:0] din;
  logic [ADDR_W-1:0] addr;

  modport master (output cmd, sz, op, fetching, din, addr);
  modport slave  (input  cmd, sz, op, fetching, din, addr);
endinterface

// File: rtl/cmd_bus_checker.sv
// Passive protocol checker for the driver -> DDR2 controller command bus.
// Tracks each command through pending / accept / block-write data phases,
// flags HOLD, TIMEOUT, OVERLAP, ROW and OP violations and counts accepted
// commands per opcode.
// Ports:
//   clk, reset  : clock, asynchronous active-high reset
//   bus         : command bus tap (slave modport, inputs only)
//   clr         : synchronous clear of flags and counters (FSM untouched)
//   err_flags   : sticky [0]HOLD [1]TIMEOUT [2]OVERLAP [3]ROW [4]OP
//   err_pulse   : one cycle high after any violation cycle
//   first_err   : lowest-index violation of the first violating cycle
//   first_valid : first_err valid
//   err_count   : violation cycles, saturating
//   cmd_cnt     : accepted commands, slice k = opcode k, saturating
//   state       : 0 IDLE, 1 PEND, 2 BLKW
module cmd_bus_checker #(
  parameter int ADDR_W    = 25,
  parameter int DATA_W    = 16,
  parameter int ROW_LSB   = 12,
  parameter int ROW_W     = 13,
  parameter int ROW_MAX   = 8191,
  parameter int OP_MAX    = 7,
  parameter int BLK_BEATS = 8,
  parameter int MAX_WAIT  = 64,
  parameter int CNT_W     = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  cmd_bus_checker_if.slave       bus,
  input  logic                   clr,
  output logic [4:0]             err_flags,
  output logic                   err_pulse,
  output logic [2:0]             first_err,
  output logic                   first_valid,
  output logic [CNT_W-1:0]       err_count,
  output logic [7:0][CNT_W-1:0]  cmd_cnt,
  output logic [1:0]             state
);
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam int BEAT_W = $clog2(4 * BLK_BEATS + 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_PEND = 2'd1, S_BLKW = 2'd2} st_t;

  typedef struct packed {
    logic [2:0]        cmd;
    logic [1:0]        sz;
    logic [2:0]        op;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] din;
  } fields_t;

  st_t               st;
  fields_t           cur, lat;
  logic [WAIT_W-1:0] wait_cnt;
  logic [BEAT_W-1:0] beats;

  logic                  active, accept, row_bad, op_bad;
  logic [4:0]            viol;
  logic [2:0]            low;
  logic                  fv_nxt;
  logic [2:0]            fe_nxt;
  logic [CNT_W-1:0]      ec_nxt;
  logic [7:0][CNT_W-1:0] cc_nxt;

  assign cur    = '{cmd: bus.cmd, sz: bus.sz, op: bus.op, addr: bus.addr, din: bus.din};
  assign active = (cur.cmd != 3'd0) && (cur.cmd != 3'd7);
  assign state  = st;

  // Range checks only exist when the legal range is narrower than the field.
  generate
    if (ROW_MAX < (2 ** ROW_W) - 1) begin : g_row
      assign row_bad = bus.addr[ROW_LSB +: ROW_W] > ROW_W'(ROW_MAX);
    end else begin : g_norow
      assign row_bad = 1'b0;
    end
    if (OP_MAX < 7) begin : g_op
      assign op_bad = bus.op > 3'(OP_MAX);
    end else begin : g_noop
      assign op_bad = 1'b0;
    end
  endgenerate

  always_comb begin
    viol   = '0;
    accept = 1'b0;
    case (st)
      S_IDLE: accept = active && bus.fetching;
      S_PEND: begin
        if (cur != lat) viol[0] = 1'b1;
        accept = active && bus.fetching;
        // Fires on the cycle the wait count would reach MAX_WAIT; the
        // counter parks there so it cannot fire again.
        if (active && !bus.fetching && wait_cnt == WAIT_W'(MAX_WAIT - 1)) viol[1] = 1'b1;
      end
      S_BLKW: if (active && bus.fetching) viol[2] = 1'b1;
      default: ;
    endcase
    if (accept) begin
      viol[3] = row_bad;
      viol[4] = op_bad && (cur.cmd == 3'd5 || cur.cmd == 3'd6);
    end

    low = 3'd0;
    for (int i = 4; i >= 0; i--) if (viol[i]) low = 3'(i);

    // clr is applied first, then this cycle's events are layered on top.
    fv_nxt = clr ? 1'b0 : first_valid;
    fe_nxt = clr ? 3'd0 : first_err;
    if (!fv_nxt && |viol) begin
      fv_nxt = 1'b1;
      fe_nxt = low;
    end

    ec_nxt = clr ? '0 : err_count;
    if (|viol && ec_nxt != '1) ec_nxt = ec_nxt + CNT_W'(1);

    for (int k = 0; k < 8; k++) begin
      cc_nxt[k] = clr ? '0 : cmd_cnt[k];
      if (accept && cur.cmd == 3'(k) && cc_nxt[k] != '1) cc_nxt[k] = cc_nxt[k] + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st          <= S_IDLE;
      lat         <= '0;
      wait_cnt    <= '0;
      beats       <= '0;
      err_flags   <= '0;
      err_pulse   <= 1'b0;
      first_err   <= '0;
      first_valid <= 1'b0;
      err_count   <= '0;
      cmd_cnt     <= '0;
    end else begin
      case (st)
        S_IDLE: begin
          if (accept) begin
            if (cur.cmd == 3'd4) begin
              st    <= S_BLKW;
              beats <= BEAT_W'((int'(cur.sz) + 1) * BLK_BEATS);
            end
          end else if (active) begin
            st       <= S_PEND;
            lat      <= cur;
            wait_cnt <= WAIT_W'(1);
          end
        end
        S_PEND: begin
          if (!active) begin
            st <= S_IDLE;
          end else if (accept) begin
            if (cur.cmd == 3'd4) begin
              st    <= S_BLKW;
              beats <= BEAT_W'((int'(cur.sz) + 1) * BLK_BEATS);
            end else begin
              st <= S_IDLE;
            end
          end else begin
            // Relatch so one field change is reported once, not every cycle.
            lat <= cur;
            if (wait_cnt != WAIT_W'(MAX_WAIT)) wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        S_BLKW: begin
          if (bus.fetching) begin
            beats <= beats - BEAT_W'(1);
            if (beats == BEAT_W'(1)) st <= S_IDLE;
          end
        end
        default: st <= S_IDLE;
      endcase

      err_flags   <= (clr ? 5'd0 : err_flags) | viol;
      err_pulse   <= |viol;
      first_err   <= fe_nxt;
      first_valid <= fv_nxt;
      err_count   <= ec_nxt;
      cmd_cnt     <= cc_nxt;
    end
  end
endmodule

// File: tb/tb_cmd_bus_checker.sv
// Bench for cmd_bus_checker. Three checkers tap one bus: default parameters,
// a narrow-range variant (ROW_MAX=4095, OP_MAX=5) and a 4-bit-counter variant.
module tb_cmd_bus_checker;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic clr = 1'b0;
  always #5 clk = ~clk;

  cmd_bus_checker_if #(.ADDR_W(25), .DATA_W(16)) bus ();

  logic [4:0]        fl, fl_r, fl_s;
  logic              pu, pu_r, pu_s;
  logic [2:0]        fe, fe_r, fe_s;
  logic              fv, fv_r, fv_s;
  logic [15:0]       ec, ec_r;
  logic [3:0]        ec_s;
  logic [7:0][15:0]  cc, cc_r;
  logic [7:0][3:0]   cc_s;
  logic [1:0]        st, st_r, st_s;

  cmd_bus_checker dut (
    .clk(clk), .reset(reset), .bus(bus), .clr(clr),
    .err_flags(fl), .err_pulse(pu), .first_err(fe), .first_valid(fv),
    .err_count(ec), .cmd_cnt(cc), .state(st));

  cmd_bus_checker #(.ROW_MAX(4095), .OP_MAX(5)) dut_r (
    .clk(clk), .reset(reset), .bus(bus), .clr(clr),
    .err_flags(fl_r), .err_pulse(pu_r), .first_err(fe_r), .first_valid(fv_r),
    .err_count(ec_r), .cmd_cnt(cc_r), .state(st_r));

  cmd_bus_checker #(.CNT_W(4)) dut_s (
    .clk(clk), .reset(reset), .bus(bus), .clr(clr),
    .err_flags(fl_s), .err_pulse(pu_s), .first_err(fe_s), .first_valid(fv_s),
    .err_count(ec_s), .cmd_cnt(cc_s), .state(st_s));

  typedef struct {
    logic [2:0]  cmd;
    logic [1:0]  sz;
    logic [2:0]  op;
    logic        fetch;
    logic [24:0] addr;
    logic        clr;
    logic [4:0]  flags;
    logic        pulse;
    logic [1:0]  state;
    logic [15:0] cnt;
    logic [3:0]  first;   // {valid, idx}
    logic [4:0]  rflags;
    logic [15:0] rcnt;
    logic [3:0]  rfirst;
  } vec_t;

  localparam int NV = 14;
  localparam logic [24:0] A = 25'h0005000;  // row 5
  localparam logic [24:0] B = 25'h0005008;  // row 5, other column

  vec_t tv[NV];
  int   n_pass = 0;
  int   n_tot  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] c, input logic [1:0] s, input logic [2:0] o,
                       input logic f, input logic [24:0] a);
    bus.cmd = c; bus.sz = s; bus.op = o; bus.fetching = f; bus.addr = a;
  endtask

  initial begin
    tv[0]  = '{3'd0, 2'd0, 3'd0, 1'b0, 25'd0, 1'b1, 5'h00, 1'b0, 2'd0, 16'd0, 4'h0, 5'h00, 16'd0, 4'h0};
    tv[1]  = '{3'd2, 2'd0, 3'd0, 1'b1, A,     1'b0, 5'h00, 1'b0, 2'd0, 16'd0, 4'h0, 5'h00, 16'd0, 4'h0};
    tv[2]  = '{3'd0, 2'd0, 3'd0, 1'b0, 25'd0, 1'b0, 5'h00, 1'b0, 2'd0, 16'd0, 4'h0, 5'h00, 16'd0, 4'h0};
    tv[3]  = '{3'd1, 2'd0, 3'd0, 1'b0, A,     1'b0, 5'h00, 1'b0, 2'd1, 16'd0, 4'h0, 5'h00, 16'd0, 4'h0};
    tv[4]  = '{3'd1, 2'd0, 3'd0, 1'b0, A,     1'b0, 5'h00, 1'b0, 2'd1, 16'd0, 4'h0, 5'h00, 16'd0, 4'h0};
    tv[5]  = '{3'd1, 2'd0, 3'd0, 1'b0, B,     1'b0, 5'h01, 1'b1, 2'd1, 16'd1, 4'h8, 5'h01, 16'd1, 4'h8};
    tv[6]  = '{3'd1, 2'd0, 3'd0, 1'b0, B,     1'b0, 5'h01, 1'b0, 2'd1, 16'd1, 4'h8, 5'h01, 16'd1, 4'h8};
    tv[7]  = '{3'd1, 2'd0, 3'd0, 1'b1, B,     1'b0, 5'h01, 1'b0, 2'd0, 16'd1, 4'h8, 5'h01, 16'd1, 4'h8};
    tv[8]  = '{3'd0, 2'd0, 3'd0, 1'b0, 25'd0, 1'b1, 5'h00, 1'b0, 2'd0, 16'd0, 4'h0, 5'h00, 16'd0, 4'h0};
    // ATW op 7, row 8191: legal on defaults; ROW and OP on the narrow variant.
    tv[9]  = '{3'd6, 2'd0, 3'd7, 1'b1, 25'h1FFF000, 1'b0, 5'h00, 1'b0, 2'd0, 16'd0, 4'h0, 5'h18, 16'd1, 4'hB};
    tv[10] = '{3'd0, 2'd0, 3'd0, 1'b0, 25'd0, 1'b0, 5'h00, 1'b0, 2'd0, 16'd0, 4'h0, 5'h18, 16'd1, 4'hB};
    // Clear together with a row-4096 ATR: the new ROW survives the clear.
    tv[11] = '{3'd5, 2'd0, 3'd3, 1'b1, 25'h1000000, 1'b1, 5'h00, 1'b0, 2'd0, 16'd0, 4'h0, 5'h08, 16'd1, 4'hB};
    // op is not range-checked for SCR.
    tv[12] = '{3'd1, 2'd0, 3'd7, 1'b1, A,     1'b0, 5'h00, 1'b0, 2'd0, 16'd0, 4'h0, 5'h08, 16'd1, 4'hB};
    tv[13] = '{3'd0, 2'd0, 3'd0, 1'b0, 25'd0, 1'b1, 5'h00, 1'b0, 2'd0, 16'd0, 4'h0, 5'h00, 16'd0, 4'h0};

    bus.din = '0;
    drive(3'd0, 2'd0, 3'd0, 1'b0, 25'd0);
    repeat (2) step();
    chk("rst_flags", fl, 0);
    chk("rst_pulse", pu, 0);
    chk("rst_first", {fv, fe}, 0);
    chk("rst_cnt", ec, 0);
    chk("rst_cmdcnt", cc, 0);
    chk("rst_state", st, 0);
    reset = 1'b0;
    step();

    for (int i = 0; i < NV; i++) begin
      drive(tv[i].cmd, tv[i].sz, tv[i].op, tv[i].fetch, tv[i].addr);
      clr = tv[i].clr;
      step();
      chk($sformatf("v%0d_flags", i), fl, tv[i].flags);
      chk($sformatf("v%0d_pulse", i), pu, tv[i].pulse);
      chk($sformatf("v%0d_state", i), st, tv[i].state);
      chk($sformatf("v%0d_cnt", i), ec, tv[i].cnt);
      chk($sformatf("v%0d_first", i), {fv, fe}, tv[i].first);
      chk($sformatf("v%0d_rflags", i), fl_r, tv[i].rflags);
      chk($sformatf("v%0d_rcnt", i), ec_r, tv[i].rcnt);
      chk($sformatf("v%0d_rfirst", i), {fv_r, fe_r}, tv[i].rfirst);
    end
    clr = 1'b0;

    // Single-cycle SCW accept.
    drive(3'd2, 2'd0, 3'd0, 1'b1, A); step();
    chk("scw_cnt2", cc[2], 1);
    chk("scw_state", st, 0);
    chk("scw_flags", fl, 0);

    // BLKW sz=1: 16 beats, an idle gap does not count.
    drive(3'd4, 2'd1, 3'd0, 1'b1, A); step();
    chk("blkw_state", st, 2);
    chk("blkw_cnt4", cc[4], 1);
    drive(3'd0, 2'd0, 3'd0, 1'b1, 25'd0);
    repeat (8) step();
    bus.fetching = 1'b0; step();
    bus.fetching = 1'b1;
    repeat (7) step();
    chk("blkw_15beats", st, 2);
    step();
    chk("blkw_done", st, 0);
    chk("blkw_noerr", fl, 0);

    // Overlap: SCR with fetching on the last beat.
    drive(3'd4, 2'd1, 3'd0, 1'b1, A); step();
    drive(3'd0, 2'd0, 3'd0, 1'b1, 25'd0);
    repeat (15) step();
    drive(3'd1, 2'd0, 3'd0, 1'b1, A); step();
    chk("ovl_flags", fl, 5'h04);
    chk("ovl_pulse", pu, 1);
    chk("ovl_state", st, 0);
    chk("ovl_cnt1", cc[1], 0);
    chk("ovl_cnt4", cc[4], 2);

    // Timeout: BLKR held without fetching.
    drive(3'd0, 2'd0, 3'd0, 1'b0, 25'd0); clr = 1'b1; step(); clr = 1'b0;
    drive(3'd3, 2'd2, 3'd0, 1'b0, B);
    for (int i = 1; i <= 70; i++) begin
      step();
      if (i == 63) chk("to_63", fl, 0);
      if (i == 64) begin
        chk("to_64_flags", fl, 5'h02);
        chk("to_64_pulse", pu, 1);
        chk("to_64_first", {fv, fe}, 4'h9);
      end
    end
    chk("to_once_cnt", ec, 1);
    chk("to_once_pulse", pu, 0);
    chk("to_pend", st, 1);
    bus.fetching = 1'b1; step();
    chk("to_acc_state", st, 0);
    chk("to_acc_cnt3", cc[3], 1);
    chk("to_acc_ec", ec, 1);

    // Saturation on the 4-bit variant, then clear.
    drive(3'd0, 2'd0, 3'd0, 1'b0, 25'd0); clr = 1'b1; step(); clr = 1'b0;
    drive(3'd1, 2'd0, 3'd0, 1'b1, A);
    repeat (20) step();
    chk("sat_s_cnt1", cc_s[1], 15);
    chk("sat_cnt1", cc[1], 20);
    drive(3'd0, 2'd0, 3'd0, 1'b0, 25'd0); clr = 1'b1; step(); clr = 1'b0;
    chk("sat_clr", cc_s[1], 0);

    // Reset in the middle of a block write.
    drive(3'd4, 2'd0, 3'd0, 1'b1, A); step();
    chk("mid_blkw", st, 2);
    drive(3'd0, 2'd0, 3'd0, 1'b1, 25'd0);
    repeat (3) step();
    reset = 1'b1; #1;
    chk("async_rst_state", st, 0);
    chk("async_rst_cnt", cc[4], 0);
    step();
    reset = 1'b0;
    step();
    chk("post_rst_state", st, 0);
    chk("post_rst_flags", fl, 0);
    chk("post_rst_pulse", pu, 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
